// File: rtl/sine_lut_if.sv
// Phase-index / sine-sample bundle between a channel's DDS folding logic
// (master) and its quarter-wave sine lookup (slave).
interface sine_lut_if;
  logic [12:0] v;   // first-quadrant phase index, 0..8191
  logic [15:0] sv;  // registered sine sample, bit 15 always 0

  modport master (output v, input sv);
  modport slave  (input v, output sv);
endinterface

// File: rtl/sine_lut.sv
// Quarter-wave sine lookup: 13-bit first-quadrant index -> 16-bit sample.
// A 257-knot table with 4 fraction bits is linearly interpolated over
// 32-step segments and the result is registered. The knots sit at the
// half-step bin centres (32k + 0.5), so ~v mirrors v exactly. The extra
// knot 256 lies just past pi/2. Keeping fraction bits in the knots holds
// the worst-case error well under 1 LSB. Both the knots and the
// interpolation are monotonic, so the output is non-decreasing in v.
module sine_lut (
  input  logic        clk,
  input  logic        rst,
  sine_lut_if.slave   bus
);

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;

  // Knot k = round(16 * 32767 * sin(pi * (64k + 1) / 32768)).
  // Computed at elaboration with a Q30 Taylor series. Nine terms are
  // exact to well below 1e-9 for angles up to pi/2.
  function automatic logic [19:0] knot_value(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (PI_Q30 * longint'(64 * k + 1)) / 64'sd32768;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return 20'((sum * 64'sd524272 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [19:0] knot [0:256];

  for (genvar gi = 0; gi <= 256; gi++) begin : g_knot
    localparam logic [19:0] KNOT_VAL = knot_value(gi);
    assign knot[gi] = KNOT_VAL;
  end

  logic [7:0]  seg;
  logic [4:0]  frac;
  logic [19:0] lo;
  logic [19:0] hi;
  logic [19:0] slope;
  logic [25:0] prod;
  logic [25:0] acc;
  logic [16:0] rounded;
  logic [14:0] sat;
  logic [15:0] sv_reg;

  // Interpolate between the two knots bracketing v.
  // The accumulator is in 1/512 LSB units; round half-up and clamp to full scale.
  always_comb begin
    seg     = bus.v[12:5];
    frac    = bus.v[4:0];
    lo      = knot[{1'b0, seg}];
    hi      = knot[{1'b0, seg} + 9'd1];
    slope   = hi - lo;
    prod    = 26'(slope) * 26'(frac);
    acc     = {1'b0, lo, 5'b00000} + prod;
    rounded = 17'((acc + 26'd256) >> 9);
    sat     = (rounded > 17'd32767) ? 15'h7FFF : rounded[14:0];
  end

  // Output register: cleared immediately by reset and reloaded on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv_reg <= 16'h0000;
    end else begin
      sv_reg <= {1'b0, sat};
    end
  end

  assign bus.sv = sv_reg;

endmodule

// File: tb/tb_sine_lut.sv
// Self-checking bench for sine_lut: reset behaviour, table-driven
// spot values, an exhaustive monotonic sweep, pipelining, random
// lookups against a real-valued sine model, and a mid-stream reset.
module tb_sine_lut;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sine_lut_if bus ();

  sine_lut dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the ideal sample from the sine itself.
  function automatic int ideal(input int v);
    real a;
    a = 3.14159265358979324 * real'(2 * v + 1) / 32768.0;
    return int'(32767.0 * $sin(a));
  endfunction

  task automatic check(input string name, input int got, input int exp, input int tol);
    tests++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, got, exp, tol);
    end
  endtask

  typedef struct {
    logic [12:0] v;
    int          exp;
    int          tol;
  } vec_t;

  vec_t vecs [0:6];

  int prev;
  int got;
  int last_v;
  logic [12:0] rv;

  initial begin
    vecs[0] = '{13'd0,    3,     1};
    vecs[1] = '{13'd8191, 32767, 0};
    vecs[2] = '{13'd4095, 23168, 1};
    vecs[3] = '{13'd4096, 23172, 1};
    vecs[4] = '{13'h0100, 1611,  1};
    vecs[5] = '{13'h1EFF, 32727, 1};
    vecs[6] = '{13'd31,   ideal(31), 1};

    // Reset hold with clock running, then release and one edge
    bus.v = 13'd8191;
    rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", int'(bus.sv), 0, 0);
    $display("[TB] reset hold: sv=%0d", bus.sv);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("reset_release", int'(bus.sv), 32767, 0);
    $display("[TB] reset release v=8191: sv=%0d", bus.sv);

    // Table-driven spot values
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk) bus.v = vecs[i].v;
      @(posedge clk);
      #1;
      check("table_value", int'(bus.sv), vecs[i].exp, vecs[i].tol);
      check("table_bit15", int'(bus.sv[15]), 0, 0);
      $display("[TB] table v=%0d: sv=%0d expect %0d", vecs[i].v, bus.sv, vecs[i].exp);
    end

    // Exhaustive sweep, one index per cycle, checked one cycle later
    @(negedge clk) bus.v = 13'd0;
    prev = 0;
    for (int i = 1; i <= 8192; i++) begin
      @(negedge clk);
      got = int'(bus.sv);
      check("sweep_value", got, ideal(i - 1), 1);
      check("sweep_bit15", int'(bus.sv[15]), 0, 0);
      if (i > 1) begin
        tests++;
        if (got < prev) begin
          fails++;
          $display("FAIL sweep_monotonic: v=%0d got %0d, previous %0d", i - 1, got, prev);
        end
      end
      prev = got;
      if (i < 8192) bus.v = 13'(i);
    end
    $display("[TB] sweep 0..8191 complete");

    // Pipelining: alternate extremes every cycle
    last_v = 8191;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (last_v == 0) check("pipe_low", int'(bus.sv), 3, 1);
        else             check("pipe_high", int'(bus.sv), 32767, 0);
        $display("[TB] pipe v=%0d: sv=%0d", last_v, bus.sv);
      end
      last_v = (i % 2 == 0) ? 0 : 8191;
      bus.v  = 13'(last_v);
    end

    // Random lookups, streamed back to back
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      rv    = 13'($urandom_range(0, 8191));
      bus.v = rv;
      @(negedge clk);
      check("random_value", int'(bus.sv), ideal(int'(rv)), 1);
      $display("[TB] random v=%0d: sv=%0d ideal %0d", rv, bus.sv, ideal(int'(rv)));
    end

    // Mid-stream reset: half-cycle low pulse discards the in-flight lookup
    @(negedge clk) bus.v = 13'd1000;
    @(posedge clk);
    #1 check("midrst_before", int'(bus.sv), ideal(1000), 1);
    #1 rst = 1'b0;
    #1 check("midrst_async", int'(bus.sv), 0, 0);
    @(negedge clk);
    check("midrst_held", int'(bus.sv), 0, 0);
    rst   = 1'b1;
    bus.v = 13'd5000;
    #1 check("midrst_no_edge", int'(bus.sv), 0, 0);
    @(posedge clk);
    #1 check("midrst_resume", int'(bus.sv), ideal(5000), 1);
    $display("[TB] mid-stream reset: resumed sv=%0d for v=5000", bus.sv);
    @(negedge clk) bus.v = 13'd5001;
    @(posedge clk);
    #1 check("midrst_next", int'(bus.sv), ideal(5001), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_lut.md
# sine_lut

Quarter-wave sine lookup used by the spread-spectrum correlator channels. It converts a 13-bit first-quadrant phase index into a 16-bit two's-complement sine magnitude, with a registered output. The caller folds a full 32-bit DDS phase into this quadrant and applies any sign inversion itself: index = phase[29:17], bit-inverted in quadrants 1 and 3, and output negated in quadrants 2 and 3. One instance sits beside each channel's DDS, feeding the sample × reference product.

## Interface
- No parameters; table size (8192 entries) and output scaling (32767 full scale) are fixed.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; the output register clears while rst = 0.
- v  input  13  first-quadrant phase index, 0..8191; the full range is legal.
- sv  output  16  two's-complement sine sample; bit 15 is always 0.

## Operation
- Ideal function: sv(v) = round(32767 · sin(π·(2v+1)/32768)).
  - This is sin over (0, π/2), sampled at the half-step centre of each of the 8192 bins.
  - The half-step offset makes ~v the exact mirror of v. The caller relies on this for quadrants 1 and 3.
- Accuracy:
  - |sv − ideal| ≤ 1 LSB for every v.
  - The sequence is monotonic non-decreasing in v.
  - Range is 3..32767 inclusive; sv is never 0 or negative out of reset.
- Implementation freedom:
  - Allowed: a full 8192×15-bit ROM initialised from a generated hex file, or a coarse table (≥ 256 entries) with linear interpolation.
  - Either must meet the accuracy rule above.
  - Bit 15 is tied to 0.
- No sign handling, quadrant folding or phase accumulation inside this block.
- Interpolation variant:
  - Upper index bits select the segment; lower bits weight the slope.
  - Intermediate products use full precision, rounded half-up, then saturated to 32767.

## Timing
- Latency: exactly 1 clock. sv after edge k reflects v sampled at edge k.
- Fully pipelined: a new v is accepted every cycle, with no stall or handshake.
- sv is held constant between edges and depends only on the registered value, never combinationally on v.
- Reset:
  - rst low forces sv = 16'h0000 immediately, without waiting for a clock, and holds it for the whole low period.
  - Asserting reset mid-stream discards the in-flight lookup.
  - After reset deasserts, the first clock edge loads table[v]. There is no extra warm-up cycle.
- Boundary inputs:
  - v = 0 gives 3.
  - v = 8191 gives 32767, the maximum, with no wrap or overflow into bit 15.
  - v is taken modulo nothing: all 13-bit values are valid.
- X on v must not corrupt state beyond the single output it produces.

## Test plan
- Reset: hold rst = 0 with v = 8191 and toggle clk → sv = 0. Release rst and apply one edge → sv = 32767.
- End points: v = 0 → sv = 3 ±1. v = 8191 → sv = 32767 (exact, never exceeds).
- Octant: v = 4095 → 23168 ±1. v = 4096 → 23172 ±1. Also check sv(v) + sv(~v) behaviour by mirror: sv(0x0100) equals the ideal at 0x0100, and sv(0x1EFF) equals the ideal at 0x1EFF, each ±1.
- Exhaustive sweep: v = 0..8191 on consecutive cycles → each sv, one cycle later, is within ±1 of the ideal, sv[15] = 0 throughout, and the sequence is non-decreasing.
- Pipelining: alternate v = 0, 8191, 0, 8191 every cycle → sv alternates 3, 32767, ... with a one-cycle lag and no skipped values.
- Mid-stream reset: pulse rst low for half a cycle during a sweep → sv drops to 0 asynchronously, then resumes the correct lookup on the first edge after release.
